// File: rtl/hazard_pkg.sv
// Shared types and constants for the multi-cycle-aware hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    S_RUN = 2'b00,
    S_LU  = 2'b01,
    S_MC  = 2'b10
  } hu_state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned LU_CNT_W = 3;

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline, slave is the hazard unit.
interface hazard_ctrl_mc_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic [REG_AW-1:0] i_hu_Rs1D, i_hu_Rs2D;
  logic              i_hu_Rs1UsedD, i_hu_Rs2UsedD;
  logic [REG_AW-1:0] i_hu_Rs1E, i_hu_Rs2E, i_hu_RdE;
  logic [REG_AW-1:0] i_hu_RdM, i_hu_RdW;
  logic              i_hu_RegWriteM, i_hu_RegWriteW;
  logic              i_hu_ResultSrcE0, i_hu_PCSrcE;
  logic              i_hu_McStartE, i_hu_McDoneE;
  logic              i_hu_MemReqM, i_hu_MemReadyM;
  logic              i_hu_CntClr;
  logic              o_hu_StallF, o_hu_StallD, o_hu_StallE, o_hu_StallM;
  logic              o_hu_FlushD, o_hu_FlushE, o_hu_FlushM, o_hu_FlushW;
  logic [1:0]        o_hu_ForwardAE, o_hu_ForwardBE;
  logic [CNT_W-1:0]  o_hu_StallCycles;

  modport master (
    output i_hu_Rs1D, i_hu_Rs2D, i_hu_Rs1UsedD, i_hu_Rs2UsedD,
           i_hu_Rs1E, i_hu_Rs2E, i_hu_RdE, i_hu_RdM, i_hu_RdW,
           i_hu_RegWriteM, i_hu_RegWriteW, i_hu_ResultSrcE0, i_hu_PCSrcE,
           i_hu_McStartE, i_hu_McDoneE, i_hu_MemReqM, i_hu_MemReadyM, i_hu_CntClr,
    input  o_hu_StallF, o_hu_StallD, o_hu_StallE, o_hu_StallM,
           o_hu_FlushD, o_hu_FlushE, o_hu_FlushM, o_hu_FlushW,
           o_hu_ForwardAE, o_hu_ForwardBE, o_hu_StallCycles
  );

  modport slave (
    input  i_hu_Rs1D, i_hu_Rs2D, i_hu_Rs1UsedD, i_hu_Rs2UsedD,
           i_hu_Rs1E, i_hu_Rs2E, i_hu_RdE, i_hu_RdM, i_hu_RdW,
           i_hu_RegWriteM, i_hu_RegWriteW, i_hu_ResultSrcE0, i_hu_PCSrcE,
           i_hu_McStartE, i_hu_McDoneE, i_hu_MemReqM, i_hu_MemReadyM, i_hu_CntClr,
    output o_hu_StallF, o_hu_StallD, o_hu_StallE, o_hu_StallM,
           o_hu_FlushD, o_hu_FlushE, o_hu_FlushM, o_hu_FlushW,
           o_hu_ForwardAE, o_hu_ForwardBE, o_hu_StallCycles
  );
endinterface

// File: rtl/fwd_sel.sv
// E-stage operand forward select for one source register; M beats W, x0 never forwards.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output fwd_sel_t          sel
);

  logic rs_nz;

  always_comb begin
    rs_nz = (rs != REG_AW'(REG_ZERO));
    sel   = FWD_RF;
    if (rs_nz && reg_write_m && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (rs_nz && reg_write_w && (rd_w == rs)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// 5-stage RV32I hazard unit: forwarding, load-use bubbles, multi-cycle execute and
// data-memory wait stalls, plus a saturating stall-cycle counter.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW          = 5,
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  hazard_ctrl_mc_if.slave hu
);

  hu_state_t           state, state_n;
  logic [LU_CNT_W-1:0] lu_cnt, lu_cnt_n;
  logic [CNT_W-1:0]    stall_cnt;
  fwd_sel_t            fwd_a, fwd_b;
  logic                lu_hit, mem_wait, mc_wait;
  logic                stall_f, stall_d, stall_e, stall_m;
  logic                flush_d, flush_e, flush_m, flush_w;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs(hu.i_hu_Rs1E), .rd_m(hu.i_hu_RdM), .rd_w(hu.i_hu_RdW),
    .reg_write_m(hu.i_hu_RegWriteM), .reg_write_w(hu.i_hu_RegWriteW), .sel(fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs(hu.i_hu_Rs2E), .rd_m(hu.i_hu_RdM), .rd_w(hu.i_hu_RdW),
    .reg_write_m(hu.i_hu_RegWriteM), .reg_write_w(hu.i_hu_RegWriteW), .sel(fwd_b)
  );

  always_comb begin
    lu_hit = hu.i_hu_ResultSrcE0 && (hu.i_hu_RdE != REG_AW'(REG_ZERO)) &&
             ((hu.i_hu_Rs1UsedD && (hu.i_hu_Rs1D == hu.i_hu_RdE)) ||
              (hu.i_hu_Rs2UsedD && (hu.i_hu_Rs2D == hu.i_hu_RdE)));
    mem_wait = hu.i_hu_MemReqM && !hu.i_hu_MemReadyM;
    mc_wait  = hu.i_hu_McStartE && !hu.i_hu_McDoneE;
  end

  // Whole priority chain sits under rst_n so every control output reads 0 during reset.
  always_comb begin
    state_n  = state;
    lu_cnt_n = lu_cnt;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    flush_w  = 1'b0;
    if (i_rst_n) begin
      if (mem_wait) begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        flush_w = 1'b1;
      end else if (mc_wait) begin
        {stall_f, stall_d, stall_e} = 3'b111;
        flush_m  = 1'b1;
        lu_cnt_n = '0;
        state_n  = S_MC;
      end else if (hu.i_hu_PCSrcE) begin
        flush_d  = 1'b1;
        flush_e  = 1'b1;
        lu_cnt_n = '0;
        state_n  = S_RUN;
      end else begin
        case (state)
          S_RUN: begin
            if (lu_hit) begin
              stall_f = 1'b1;
              stall_d = 1'b1;
              flush_e = 1'b1;
              if (LU_STALL_CYCLES > 1) begin
                lu_cnt_n = LU_CNT_W'(LU_STALL_CYCLES - 1);
                state_n  = S_LU;
              end
            end
          end
          S_LU: begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            flush_e  = 1'b1;
            lu_cnt_n = lu_cnt - 1'b1;
            if (lu_cnt == LU_CNT_W'(1)) state_n = S_RUN;
          end
          S_MC:    state_n = S_RUN;
          default: state_n = S_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_RUN;
      lu_cnt <= '0;
    end else begin
      state  <= state_n;
      lu_cnt <= lu_cnt_n;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                           stall_cnt <= '0;
    else if (hu.i_hu_CntClr)                stall_cnt <= '0;
    else if (stall_f && (stall_cnt != '1))  stall_cnt <= stall_cnt + 1'b1;
  end

  assign hu.o_hu_StallF      = stall_f;
  assign hu.o_hu_StallD      = stall_d;
  assign hu.o_hu_StallE      = stall_e;
  assign hu.o_hu_StallM      = stall_m;
  assign hu.o_hu_FlushD      = flush_d;
  assign hu.o_hu_FlushE      = flush_e;
  assign hu.o_hu_FlushM      = flush_m;
  assign hu.o_hu_FlushW      = flush_w;
  assign hu.o_hu_ForwardAE   = i_rst_n ? fwd_a : FWD_RF;
  assign hu.o_hu_ForwardBE   = i_rst_n ? fwd_b : FWD_RF;
  assign hu.o_hu_StallCycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: two instances (32-bit and 4-bit counters) share one stimulus.
module tb_hazard_ctrl_mc;

  localparam int unsigned LU = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(32)) hu_a ();
  hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(4))  hu_b ();

  hazard_ctrl_mc #(.REG_AW(5), .LU_STALL_CYCLES(LU), .CNT_W(32)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .hu(hu_a)
  );
  hazard_ctrl_mc #(.REG_AW(5), .LU_STALL_CYCLES(LU), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .hu(hu_b)
  );

  assign hu_b.i_hu_Rs1D        = hu_a.i_hu_Rs1D;
  assign hu_b.i_hu_Rs2D        = hu_a.i_hu_Rs2D;
  assign hu_b.i_hu_Rs1UsedD    = hu_a.i_hu_Rs1UsedD;
  assign hu_b.i_hu_Rs2UsedD    = hu_a.i_hu_Rs2UsedD;
  assign hu_b.i_hu_Rs1E        = hu_a.i_hu_Rs1E;
  assign hu_b.i_hu_Rs2E        = hu_a.i_hu_Rs2E;
  assign hu_b.i_hu_RdE         = hu_a.i_hu_RdE;
  assign hu_b.i_hu_RdM         = hu_a.i_hu_RdM;
  assign hu_b.i_hu_RdW         = hu_a.i_hu_RdW;
  assign hu_b.i_hu_RegWriteM   = hu_a.i_hu_RegWriteM;
  assign hu_b.i_hu_RegWriteW   = hu_a.i_hu_RegWriteW;
  assign hu_b.i_hu_ResultSrcE0 = hu_a.i_hu_ResultSrcE0;
  assign hu_b.i_hu_PCSrcE      = hu_a.i_hu_PCSrcE;
  assign hu_b.i_hu_McStartE    = hu_a.i_hu_McStartE;
  assign hu_b.i_hu_McDoneE     = hu_a.i_hu_McDoneE;
  assign hu_b.i_hu_MemReqM     = hu_a.i_hu_MemReqM;
  assign hu_b.i_hu_MemReadyM   = hu_a.i_hu_MemReadyM;
  assign hu_b.i_hu_CntClr      = hu_a.i_hu_CntClr;

  // Control bits packed as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}.
  logic [7:0] ctl_a, ctl_b;
  assign ctl_a = {hu_a.o_hu_StallF, hu_a.o_hu_StallD, hu_a.o_hu_StallE, hu_a.o_hu_StallM,
                  hu_a.o_hu_FlushD, hu_a.o_hu_FlushE, hu_a.o_hu_FlushM, hu_a.o_hu_FlushW};
  assign ctl_b = {hu_b.o_hu_StallF, hu_b.o_hu_StallD, hu_b.o_hu_StallE, hu_b.o_hu_StallM,
                  hu_b.o_hu_FlushD, hu_b.o_hu_FlushE, hu_b.o_hu_FlushM, hu_b.o_hu_FlushW};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
    if (rs != 0 && hu_a.i_hu_RegWriteM && hu_a.i_hu_RdM == rs) return 2'b10;
    if (rs != 0 && hu_a.i_hu_RegWriteW && hu_a.i_hu_RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit lu_exp();
    return hu_a.i_hu_ResultSrcE0 && hu_a.i_hu_RdE != 0 &&
           ((hu_a.i_hu_Rs1UsedD && hu_a.i_hu_Rs1D == hu_a.i_hu_RdE) ||
            (hu_a.i_hu_Rs2UsedD && hu_a.i_hu_Rs2D == hu_a.i_hu_RdE));
  endfunction

  // Reference model: bubbles still owed, whether a multi-cycle op is in flight,
  // and the number of stalled cycles since the last clear.
  int      owed = 0;
  bit      in_mc = 1'b0;
  longint  since_clr = 0;

  always @(negedge clk) begin : model
    logic [7:0] ctl;
    logic [1:0] fa, fb;
    bit         memw, mcw, stall_now;
    longint     exp_b;
    ctl = '0; fa = '0; fb = '0; memw = 1'b0; mcw = 1'b0;
    if (!rst_n) begin
      owed = 0; in_mc = 1'b0; since_clr = 0;
    end else begin
      fa   = fwd_exp(hu_a.i_hu_Rs1E);
      fb   = fwd_exp(hu_a.i_hu_Rs2E);
      memw = hu_a.i_hu_MemReqM && !hu_a.i_hu_MemReadyM;
      mcw  = hu_a.i_hu_McStartE && !hu_a.i_hu_McDoneE;
      if (memw)                                   ctl = 8'b1111_0001;
      else if (mcw)                               ctl = 8'b1110_0010;
      else if (hu_a.i_hu_PCSrcE)                  ctl = 8'b0000_1100;
      else if (owed > 0 || (!in_mc && lu_exp()))  ctl = 8'b1100_0100;
    end
    exp_b = (since_clr > 15) ? 15 : since_clr;
    check("ctl_a",  64'(ctl_a), 64'(ctl));
    check("ctl_b",  64'(ctl_b), 64'(ctl));
    check("fwd_a",  64'({hu_a.o_hu_ForwardAE, hu_a.o_hu_ForwardBE}), 64'({fa, fb}));
    check("cnt_a",  64'(hu_a.o_hu_StallCycles), 64'(since_clr));
    check("cnt_b",  64'(hu_b.o_hu_StallCycles), 64'(exp_b));
    if (rst_n) begin
      stall_now = ctl[7];
      if (memw) begin
      end else if (mcw) begin
        in_mc = 1'b1; owed = 0;
      end else if (hu_a.i_hu_PCSrcE) begin
        in_mc = 1'b0; owed = 0;
      end else if (owed > 0) begin
        owed--;
      end else if (in_mc) begin
        in_mc = 1'b0;
      end else if (lu_exp()) begin
        owed = LU - 1;
      end
      if (hu_a.i_hu_CntClr) since_clr = 0;
      else if (stall_now)   since_clr++;
    end
  end

  task automatic idle();
    hu_a.i_hu_Rs1D = '0; hu_a.i_hu_Rs2D = '0; hu_a.i_hu_Rs1UsedD = 1'b0; hu_a.i_hu_Rs2UsedD = 1'b0;
    hu_a.i_hu_Rs1E = '0; hu_a.i_hu_Rs2E = '0; hu_a.i_hu_RdE = '0; hu_a.i_hu_RdM = '0;
    hu_a.i_hu_RdW = '0; hu_a.i_hu_RegWriteM = 1'b0; hu_a.i_hu_RegWriteW = 1'b0;
    hu_a.i_hu_ResultSrcE0 = 1'b0; hu_a.i_hu_PCSrcE = 1'b0; hu_a.i_hu_McStartE = 1'b0;
    hu_a.i_hu_McDoneE = 1'b0; hu_a.i_hu_MemReqM = 1'b0; hu_a.i_hu_MemReadyM = 1'b0;
    hu_a.i_hu_CntClr = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lu_inputs(input bit used);
    hu_a.i_hu_ResultSrcE0 = 1'b1; hu_a.i_hu_RdE = 5'd7;
    hu_a.i_hu_Rs2D = 5'd7; hu_a.i_hu_Rs2UsedD = used;
  endtask

  initial begin
    idle();
    hu_a.i_hu_Rs1E = 5'd5; hu_a.i_hu_RdM = 5'd5; hu_a.i_hu_RegWriteM = 1'b1;
    hu_a.i_hu_McStartE = 1'b1;
    cyc(); cyc();
    check("rst_ctl", 64'(ctl_a), 64'h0);
    check("rst_fwd", 64'(hu_a.o_hu_ForwardAE), 64'h0);
    check("rst_cnt", 64'(hu_a.o_hu_StallCycles), 64'h0);
    idle();
    rst_n = 1'b1;
    cyc();

    // Forwarding priority and x0 exclusion
    hu_a.i_hu_Rs1E = 5'd5; hu_a.i_hu_RdM = 5'd5; hu_a.i_hu_RegWriteM = 1'b1;
    hu_a.i_hu_RdW = 5'd5; hu_a.i_hu_RegWriteW = 1'b1;
    #1 check("fwd_m_prio", 64'(hu_a.o_hu_ForwardAE), 64'h2);
    hu_a.i_hu_RegWriteM = 1'b0;
    #1 check("fwd_w", 64'(hu_a.o_hu_ForwardAE), 64'h1);
    hu_a.i_hu_RegWriteM = 1'b1; hu_a.i_hu_Rs1E = 5'd0;
    #1 check("fwd_x0", 64'(hu_a.o_hu_ForwardAE), 64'h0);
    hu_a.i_hu_Rs2E = 5'd9; hu_a.i_hu_RdW = 5'd9; hu_a.i_hu_RdM = 5'd3;
    #1 check("fwd_b_w", 64'(hu_a.o_hu_ForwardBE), 64'h1);
    cyc(); idle();

    // Load-use: exactly LU bubbles
    lu_inputs(1'b1);
    #1 check("lu_c1", 64'(ctl_a), 64'hC4);
    cyc();
    check("lu_c2", 64'(ctl_a), 64'hC4);
    cyc(); idle();
    #1 check("lu_release", 64'(ctl_a), 64'h00);
    lu_inputs(1'b0);
    #1 check("lu_unused", 64'(ctl_a), 64'h00);
    cyc(); idle();

    // Multi-cycle op completing on cycle 34
    hu_a.i_hu_CntClr = 1'b1;
    cyc(); idle();
    hu_a.i_hu_McStartE = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      #1 if (i == 1 || i == 33) check("mc_stall", 64'(ctl_a), 64'hE2);
      cyc();
    end
    hu_a.i_hu_McDoneE = 1'b1;
    #1 check("mc_done", 64'(ctl_a), 64'h00);
    cyc(); idle();
    check("mc_cnt_a", 64'(hu_a.o_hu_StallCycles), 64'd33);
    check("mc_cnt_b", 64'(hu_b.o_hu_StallCycles), 64'd15);
    hu_a.i_hu_McStartE = 1'b1; hu_a.i_hu_McDoneE = 1'b1;
    #1 check("mc_single", 64'(ctl_a), 64'h00);
    cyc(); idle();

    // Memory wait freezes the last load-use bubble
    lu_inputs(1'b1);
    cyc(); idle();
    hu_a.i_hu_MemReqM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("memw", 64'(ctl_a), 64'hF1);
      cyc();
    end
    hu_a.i_hu_MemReadyM = 1'b1;
    #1 check("lu_after_memw", 64'(ctl_a), 64'hC4);
    cyc(); idle();
    #1 check("lu_done_memw", 64'(ctl_a), 64'h00);

    // Branch flush, alone and cancelling a load-use sequence
    hu_a.i_hu_PCSrcE = 1'b1;
    #1 check("branch", 64'(ctl_a), 64'h0C);
    cyc(); idle();
    lu_inputs(1'b1);
    cyc(); idle();
    hu_a.i_hu_PCSrcE = 1'b1;
    #1 check("branch_in_lu", 64'(ctl_a), 64'h0C);
    cyc(); idle();
    #1 check("after_branch", 64'(ctl_a), 64'h00);

    // Asynchronous reset during a multi-cycle stall
    hu_a.i_hu_McStartE = 1'b1;
    cyc();
    check("mc_pre_rst", 64'(ctl_a), 64'hE2);
    rst_n = 1'b0;
    #1 check("mc_rst_ctl", 64'(ctl_a), 64'h00);
    check("mc_rst_cnt", 64'(hu_a.o_hu_StallCycles), 64'h0);
    cyc(); idle();
    rst_n = 1'b1;
    lu_inputs(1'b1);
    #1 check("run_after_rst", 64'(ctl_a), 64'hC4);
    cyc();
    cyc(); idle();

    // Counter saturation and clear priority
    hu_a.i_hu_CntClr = 1'b1;
    cyc(); idle();
    hu_a.i_hu_McStartE = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    hu_a.i_hu_McDoneE = 1'b1;
    cyc(); idle();
    check("sat_a", 64'(hu_a.o_hu_StallCycles), 64'd20);
    check("sat_b", 64'(hu_b.o_hu_StallCycles), 64'd15);
    hu_a.i_hu_McStartE = 1'b1; hu_a.i_hu_CntClr = 1'b1;
    cyc();
    check("clr_a", 64'(hu_a.o_hu_StallCycles), 64'd0);
    check("clr_b", 64'(hu_b.o_hu_StallCycles), 64'd0);
    hu_a.i_hu_CntClr = 1'b0;
    cyc();
    check("clr_inc", 64'(hu_a.o_hu_StallCycles), 64'd1);
    hu_a.i_hu_McDoneE = 1'b1;
    cyc(); idle();
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
